wb_txn_capture: RTL and testbench

- Synthesisable, passive Wishbone transaction tracer for the SoC IO bus (wb_m2s_io_* / wb_s2m_io_*).
- Records every completed bus cycle that matches a programmable address window into a first-word-fall-through (FWFT) FIFO.
- Each record holds address, data, direction, byte-select and wait-state count. The FIFO is drained by a debug/JTAG reader or a bench monitor.
- Generalises the fixed 32-bit signal tap into a parametrised, filtered, buffered capture unit with overflow accounting.

---
 rtl/wb_txn_capture.sv | 155 +++++++++++++++
 tb/tb_wb_txn_capture.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_txn_capture.sv
// wb_txn_capture: passive Wishbone transaction tracer.
// Completed bus cycles (cyc & stb & ack) that hit the programmable address window are
// recorded into a first-word-fall-through FIFO. Each record holds the address, data,
// direction, byte selects and wait-state count.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   wb_*                  observed Wishbone IO bus signals (inputs only, never driven)
//   cfg_enable            capture enable
//   cfg_clear             synchronous flush of the FIFO and the overflow counter
//   cfg_base, cfg_mask    address filter: (adr & mask) == (base & mask)
//   rd_en                 pop request for the head entry
//   rd_valid, rd_*        head entry of the FIFO (all zero while empty)
//   count                 FIFO occupancy, 0..DEPTH
//   overflow_cnt          saturating count of records dropped on a full FIFO
module wb_txn_capture #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WAIT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        wb_adr,
    input  logic [DATA_W-1:0]        wb_dat_m2s,
    input  logic [DATA_W-1:0]        wb_dat_s2m,
    input  logic [DATA_W/8-1:0]      wb_sel,
    input  logic                     wb_we,
    input  logic                     wb_cyc,
    input  logic                     wb_stb,
    input  logic                     wb_ack,
    input  logic                     cfg_enable,
    input  logic                     cfg_clear,
    input  logic [ADDR_W-1:0]        cfg_base,
    input  logic [ADDR_W-1:0]        cfg_mask,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [ADDR_W-1:0]        rd_adr,
    output logic [DATA_W-1:0]        rd_dat,
    output logic                     rd_we,
    output logic [DATA_W/8-1:0]      rd_sel,
    output logic [WAIT_W-1:0]        rd_wait,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              overflow_cnt
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_adr  [DEPTH];
    logic [DATA_W-1:0] mem_dat  [DEPTH];
    logic              mem_we   [DEPTH];
    logic [SEL_W-1:0]  mem_sel  [DEPTH];
    logic [WAIT_W-1:0] mem_wait [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [15:0]       ovf;

    logic bus_active;
    logic bus_event;
    logic addr_match;
    logic push_req;
    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic do_drop;

    always_comb begin
        bus_active = wb_cyc & wb_stb;
        bus_event  = bus_active & wb_ack;
        addr_match = (wb_adr & cfg_mask) == (cfg_base & cfg_mask);
        push_req   = bus_event & addr_match & cfg_enable;
        empty      = (cnt == '0);
        full       = (cnt == CNT_W'(DEPTH));
        do_pop     = rd_en & ~empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push    = push_req & (~full | do_pop);
        do_drop    = push_req & full & ~do_pop;
    end

    // Wait-state counter: counts stalled strobe cycles, restarts after each completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!bus_active || wb_ack) begin
            wait_cnt <= '0;
        end else if (wait_cnt != {WAIT_W{1'b1}}) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= '0;
        end else if (cfg_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (do_drop && ovf != 16'hFFFF) begin
                ovf <= ovf + 16'd1;
            end
        end
    end

    // Storage needs no reset: entries are only visible once counted as valid.
    always_ff @(posedge clock) begin
        if (do_push && !cfg_clear) begin
            mem_adr[wr_ptr]  <= wb_adr;
            mem_dat[wr_ptr]  <= wb_we ? wb_dat_m2s : wb_dat_s2m;
            mem_we[wr_ptr]   <= wb_we;
            mem_sel[wr_ptr]  <= wb_sel;
            mem_wait[wr_ptr] <= wait_cnt;
        end
    end

    always_comb begin
        rd_valid     = ~empty;
        rd_adr       = '0;
        rd_dat       = '0;
        rd_we        = 1'b0;
        rd_sel       = '0;
        rd_wait      = '0;
        if (!empty) begin
            rd_adr  = mem_adr[rd_ptr];
            rd_dat  = mem_dat[rd_ptr];
            rd_we   = mem_we[rd_ptr];
            rd_sel  = mem_sel[rd_ptr];
            rd_wait = mem_wait[rd_ptr];
        end
        count        = cnt;
        overflow_cnt = ovf;
    end

endmodule

// File: tb/tb_wb_txn_capture.sv
// Directed self-checking bench for wb_txn_capture (default parameters, DEPTH = 16).
module tb_wb_txn_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] wb_adr, wb_dat_m2s, wb_dat_s2m;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, wb_ack;
    logic        cfg_enable, cfg_clear;
    logic [31:0] cfg_base, cfg_mask;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_adr, rd_dat;
    logic        rd_we;
    logic [3:0]  rd_sel;
    logic [7:0]  rd_wait;
    logic [4:0]  count;
    logic [15:0] overflow_cnt;

    int checks = 0;
    int errors = 0;

    wb_txn_capture dut (
        .clock(clock), .reset(reset),
        .wb_adr(wb_adr), .wb_dat_m2s(wb_dat_m2s), .wb_dat_s2m(wb_dat_s2m),
        .wb_sel(wb_sel), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_ack(wb_ack),
        .cfg_enable(cfg_enable), .cfg_clear(cfg_clear), .cfg_base(cfg_base),
        .cfg_mask(cfg_mask), .rd_en(rd_en), .rd_valid(rd_valid), .rd_adr(rd_adr),
        .rd_dat(rd_dat), .rd_we(rd_we), .rd_sel(rd_sel), .rd_wait(rd_wait),
        .count(count), .overflow_cnt(overflow_cnt)
    );

    always #5 clock = ~clock;

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_ack = 1'b0;
    endtask

    // One transaction with 'waits' stalled strobe cycles before the ack cycle.
    task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel, input int waits);
        wb_adr = adr; wb_we = we; wb_sel = sel;
        wb_dat_m2s = we ? dat : 32'h0;
        wb_dat_s2m = we ? 32'h0 : dat;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_ack = 1'b0;
        for (int i = 0; i < waits; i++) step();
        wb_ack = 1'b1;
        step();
        bus_idle();
    endtask

    // n back-to-back single-cycle-ack writes: adr = base + 4*i, dat = 0x100 + i.
    task automatic burst(input logic [31:0] base, input int n);
        wb_we = 1'b1; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1; wb_ack = 1'b1;
        for (int i = 0; i < n; i++) begin
            wb_adr = base + 32'(4 * i);
            wb_dat_m2s = 32'h100 + 32'(i);
            step();
        end
        bus_idle();
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1; step(); cfg_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd0 || overflow_cnt !== 16'd0 || rd_adr !== 32'd0) begin
            $display("FAIL reset: valid=%0b count=%0d ovf=%0d adr=%h, want 0/0/0/0",
                     rd_valid, count, overflow_cnt, rd_adr);
            errors++;
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        txn(32'h2000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
        checks++;
        if (rd_valid !== 1'b1 || rd_adr !== 32'h2000_0004 || rd_dat !== 32'hDEAD_BEEF ||
            rd_we !== 1'b1 || rd_sel !== 4'hF || rd_wait !== 8'd0 || count !== 5'd1) begin
            $display("FAIL single_write: v=%0b adr=%h dat=%h we=%0b sel=%h wait=%0d cnt=%0d, want 1 20000004 deadbeef 1 f 0 1",
                     rd_valid, rd_adr, rd_dat, rd_we, rd_sel, rd_wait, count);
            errors++;
        end
        rd_en = 1'b1; step(); rd_en = 1'b0;
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0) begin
            $display("FAIL single_pop: count=%0d valid=%0b, want 0 0", count, rd_valid);
            errors++;
        end
    endtask

    task automatic test_read_waits();
        txn(32'h2000_0010, 1'b0, 32'h0000_00A5, 4'h1, 3);
        checks++;
        if (rd_valid !== 1'b1 || rd_we !== 1'b0 || rd_dat !== 32'hA5 || rd_wait !== 8'd3 ||
            rd_sel !== 4'h1) begin
            $display("FAIL read_waits: v=%0b we=%0b dat=%h wait=%0d sel=%h, want 1 0 a5 3 1",
                     rd_valid, rd_we, rd_dat, rd_wait, rd_sel);
            errors++;
        end
        rd_en = 1'b1; step(); rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd0 || rd_dat !== 32'd0) begin
            $display("FAIL read_pop: v=%0b count=%0d dat=%h, want 0 0 0", rd_valid, count, rd_dat);
            errors++;
        end
    endtask

    task automatic test_filter();
        cfg_base = 32'h2000_0100; cfg_mask = 32'hFFFF_FF00;
        txn(32'h2000_0108, 1'b1, 32'h1111_1111, 4'hF, 1);
        txn(32'h2000_0208, 1'b1, 32'h2222_2222, 4'hF, 0);
        step();
        checks++;
        if (count !== 5'd1 || rd_adr !== 32'h2000_0108 || rd_wait !== 8'd1) begin
            $display("FAIL filter: count=%0d adr=%h wait=%0d, want 1 20000108 1",
                     count, rd_adr, rd_wait);
            errors++;
        end
        cfg_mask = 32'h0; cfg_base = 32'h0;
        pulse_clear();
    endtask

    task automatic test_disable();
        cfg_enable = 1'b0;
        txn(32'h3000_0000, 1'b1, 32'h5, 4'hF, 0);
        cfg_enable = 1'b1;
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0) begin
            $display("FAIL disable: count=%0d valid=%0b, want 0 0", count, rd_valid);
            errors++;
        end
    endtask

    task automatic test_empty_push_pop();
        rd_en = 1'b1;
        txn(32'h4000_0000, 1'b1, 32'h77, 4'h3, 0);
        rd_en = 1'b0;
        checks++;
        if (count !== 5'd1 || rd_adr !== 32'h4000_0000 || rd_dat !== 32'h77) begin
            $display("FAIL empty_push_pop: count=%0d adr=%h dat=%h, want 1 40000000 77",
                     count, rd_adr, rd_dat);
            errors++;
        end
        pulse_clear();
    endtask

    task automatic test_overflow();
        int bad = 0;
        burst(32'h5000_0000, 20);
        checks++;
        if (count !== 5'd16 || overflow_cnt !== 16'd4) begin
            $display("FAIL overflow: count=%0d ovf=%0d, want 16 4", count, overflow_cnt);
            errors++;
        end
        for (int i = 0; i < 16; i++) begin
            if (rd_adr !== 32'h5000_0000 + 32'(4 * i) || rd_dat !== 32'h100 + 32'(i)) begin
                if (bad == 0)
                    $display("FAIL drain_order: entry %0d adr=%h dat=%h, want %h %h", i,
                             rd_adr, rd_dat, 32'h5000_0000 + 32'(4 * i), 32'h100 + 32'(i));
                bad++;
            end
            rd_en = 1'b1; step(); rd_en = 1'b0;
        end
        checks++;
        if (bad != 0) errors++;
        rd_en = 1'b1; step(); rd_en = 1'b0;
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || overflow_cnt !== 16'd4) begin
            $display("FAIL drained: count=%0d valid=%0b ovf=%0d, want 0 0 4",
                     count, rd_valid, overflow_cnt);
            errors++;
        end
    endtask

    task automatic test_full_push_pop();
        burst(32'h6000_0000, 16);
        rd_en = 1'b1;
        txn(32'h0000_AAA0, 1'b1, 32'hAAAA, 4'hF, 0);
        rd_en = 1'b0;
        checks++;
        if (count !== 5'd16 || overflow_cnt !== 16'd4 || rd_adr !== 32'h6000_0004) begin
            $display("FAIL full_push_pop: count=%0d ovf=%0d head=%h, want 16 4 60000004",
                     count, overflow_cnt, rd_adr);
            errors++;
        end
        rd_en = 1'b1;
        for (int i = 0; i < 15; i++) step();
        rd_en = 1'b0;
        checks++;
        if (count !== 5'd1 || rd_adr !== 32'h0000_AAA0 || rd_dat !== 32'hAAAA) begin
            $display("FAIL tail_entry: count=%0d adr=%h dat=%h, want 1 0000aaa0 aaaa",
                     count, rd_adr, rd_dat);
            errors++;
        end
    endtask

    task automatic test_clear();
        burst(32'h7000_0000, 20);
        checks++;
        if (count !== 5'd16 || overflow_cnt !== 16'd9) begin
            $display("FAIL pre_clear: count=%0d ovf=%0d, want 16 9", count, overflow_cnt);
            errors++;
        end
        // Event in the clear cycle must be discarded, not counted as overflow.
        wb_adr = 32'h7100_0000; wb_cyc = 1'b1; wb_stb = 1'b1; wb_ack = 1'b1; rd_en = 1'b1;
        pulse_clear();
        bus_idle(); rd_en = 1'b0;
        checks++;
        if (count !== 5'd0 || overflow_cnt !== 16'd0 || rd_valid !== 1'b0) begin
            $display("FAIL clear: count=%0d ovf=%0d valid=%0b, want 0 0 0",
                     count, overflow_cnt, rd_valid);
            errors++;
        end
    endtask

    task automatic test_reset_mid_txn();
        burst(32'h8000_0000, 17);
        wb_adr = 32'h9000_0000; wb_we = 1'b0; wb_dat_s2m = 32'h5A; wb_sel = 4'hC;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_ack = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd0 || overflow_cnt !== 16'd0 || rd_adr !== 32'd0) begin
            $display("FAIL async_reset: valid=%0b count=%0d ovf=%0d adr=%h, want 0 0 0 0",
                     rd_valid, count, overflow_cnt, rd_adr);
            errors++;
        end
        step();
        reset = 1'b0;
        step(); step();
        wb_ack = 1'b1;
        step();
        bus_idle();
        checks++;
        if (count !== 5'd1 || rd_wait !== 8'd2 || rd_dat !== 32'h5A || rd_we !== 1'b0) begin
            $display("FAIL reset_wait: count=%0d wait=%0d dat=%h we=%0b, want 1 2 5a 0",
                     count, rd_wait, rd_dat, rd_we);
            errors++;
        end
    endtask

    initial begin
        bus_idle();
        wb_adr = '0; wb_dat_m2s = '0; wb_dat_s2m = '0; wb_sel = '0; wb_we = 1'b0;
        cfg_enable = 1'b1; cfg_clear = 1'b0; cfg_base = '0; cfg_mask = '0; rd_en = 1'b0;
        reset = 1'b1;
        #1;
        test_reset();
        test_single_write();
        test_read_waits();
        test_filter();
        test_disable();
        test_empty_push_pop();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_reset_mid_txn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
